// File: rtl/alu_pkg.sv
// Operation encodings shared by the integer ALU and the multiply/divide unit.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // Same ordering as the RISC-V M-extension funct3 field.
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one bit per cycle through a single shift/add
// datapath shared by shift-add multiply and restoring division.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      op,
    input  logic            is_word_op,
    input  logic [XLEN-1:0] d0,
    input  logic [XLEN-1:0] d1,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int AW = XLEN + 2;

    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [2*XLEN-1:0] dbl_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic xlen_t sext32(input logic [31:0] v);
        xlen_t r;
        r = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic xlen_t zext32(input logic [31:0] v);
        xlen_t r;
        r = '0;
        r[31:0] = v;
        return r;
    endfunction

    state_t     state_q, state_d;
    muldiv_op_t op_q, op_d;
    logic       n32_q, n32_d;       // effective width is 32 bits
    logic       neg_q, neg_d;       // negate product / quotient
    logic       rneg_q, rneg_d;     // negate remainder
    xlen_t      a_q, a_d, y_q, y_d;
    dbl_t       acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Request-side operand preparation
    logic  in_n32, in_div, sgn0, sgn1, neg0, neg1, div_zero, div_ovf;
    xlen_t ext0, ext1, mag0, mag1, most_neg, early_res, early_y;

    always_comb begin
        in_div   = op inside {DIV, DIVU, REM, REMU};
        in_n32   = (XLEN == 32) || (is_word_op && (in_div || op == MUL));
        sgn0     = op inside {MULH, MULHSU, DIV, REM};
        sgn1     = op inside {MULH, DIV, REM};
        ext0     = d0;
        ext1     = d1;
        if (in_n32) begin
            ext0 = sgn0 ? sext32(d0[31:0]) : zext32(d0[31:0]);
            ext1 = sgn1 ? sext32(d1[31:0]) : zext32(d1[31:0]);
        end
        neg0     = sgn0 && ext0[XLEN-1];
        neg1     = sgn1 && ext1[XLEN-1];
        mag0     = neg0 ? -ext0 : ext0;
        mag1     = neg1 ? -ext1 : ext1;
        most_neg = in_n32 ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = in_div && (ext1 == '0);
        div_ovf  = (op == DIV || op == REM) && (ext0 == most_neg) && (&ext1);
        early_res = '0;
        if (div_zero) begin
            early_res = (op inside {REM, REMU}) ? ext0 : '1;
        end else if (div_ovf) begin
            early_res = (op == REM) ? '0 : ext0;
        end
        early_y = in_n32 ? sext32(early_res[31:0]) : early_res;
    end

    // Shared adder: multiply adds the multiplicand into the high half,
    // divide subtracts the divisor from the shifted partial remainder.
    logic          is_div_q, cnt_last;
    xlen_t         hi, lo, quo, rem, mul_res, div_res, calc_res, calc_y;
    logic [AW-1:0] add_x, add_y, sum;
    dbl_t          acc_step, prod_mag, prod;

    always_comb begin
        is_div_q = op_q inside {DIV, DIVU, REM, REMU};
        {hi, lo} = acc_q;
        add_x    = is_div_q ? {1'b0, hi, lo[XLEN-1]} : {2'b00, hi};
        add_y    = is_div_q ? ~{2'b00, a_q} : {2'b00, a_q};
        sum      = add_x + add_y + AW'(is_div_q);
        if (is_div_q) begin
            if (sum[AW-1]) acc_step = {add_x[XLEN-1:0], lo[XLEN-2:0], 1'b0};
            else           acc_step = {sum[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        end else begin
            acc_step = {(lo[0] ? sum[XLEN:0] : {1'b0, hi}), lo[XLEN-1:1]};
        end
        // A 32-bit multiply inside a wider register ends up left-aligned.
        prod_mag = n32_q ? (acc_step >> (XLEN - 32)) : acc_step;
        prod     = neg_q ? -prod_mag : prod_mag;
        mul_res  = (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        quo      = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        div_res  = (op_q inside {REM, REMU}) ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
        calc_res = is_div_q ? div_res : mul_res;
        calc_y   = n32_q ? sext32(calc_res[31:0]) : calc_res;
        cnt_last = (cnt_q == (n32_q ? CW'(31) : CW'(XLEN - 1)));
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d = state_q;
        op_d    = op_q;
        n32_d   = n32_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        a_d     = a_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    n32_d  = in_n32;
                    neg_d  = neg0 ^ neg1;
                    rneg_d = neg0;
                    a_d    = in_div ? mag1 : mag0;
                    acc_d  = in_div ? {{XLEN{1'b0}}, (in_n32 ? (mag0 << (XLEN - 32)) : mag0)}
                                    : {{XLEN{1'b0}}, mag1};
                    cnt_d  = '0;
                    if (div_zero || div_ovf) begin
                        y_d     = early_y;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    y_d     = calc_y;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MUL;
            n32_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            n32_q   <= n32_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = out_valid ? y_q : '0;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present on d0/d1/op/is_word_op.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 op  input  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-007 is_word_op  input  1  RV64 *W form: operate on low 32 bits, sign-extend 32-bit result.
REQ-008 d0  input  XLEN  multiplicand / dividend.
REQ-009 d1  input  XLEN  multiplier / divisor.
REQ-010 flush  input  1  abort any in-flight operation.
REQ-011 out_valid  output  1  y holds a completed result.
REQ-012 out_ready  input  1  consumer accepts y this cycle.
REQ-013 y  output  XLEN  result.

Function
REQ-014 States IDLE, CALC, DONE; in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-015 Accept on in_valid & in_ready: latch op, is_word_op, d0, d1; later input changes SHALL NOT affect the result.
REQ-016 Effective width N = 32 when is_word_op or XLEN==32, else XLEN; is_word_op SHALL be ignored for MULH/MULHSU/MULHU and when XLEN==32.
REQ-017 Word ops use operands d0[31:0], d1[31:0] (sign- or zero-extended per op) and y = sign-extension of the 32-bit result to XLEN.
REQ-018 Multiply: radix-2 shift-add on operand magnitudes, one bit per CALC cycle, 2N-bit product, sign correction afterwards; MUL returns low N bits, MULH/MULHSU/MULHU return high N bits with signed*signed, signed*unsigned, unsigned*unsigned interpretation.
REQ-019 Divide: restoring division on magnitudes, one quotient bit per CALC cycle; quotient sign = sign(d0) xor sign(d1), remainder sign = sign(d0) (signed ops only).
REQ-020 Normal latency: accept at edge of cycle t; CALC occupies exactly N cycles; out_valid SHALL first be high in cycle t+N+1.
REQ-021 Divide by zero: IDLE -> DONE directly (out_valid in cycle t+1); DIV/DIVU quotient = all ones (N bits), REM/REMU = dividend (N bits).
REQ-022 Signed overflow (d0 = most-negative N-bit, d1 = -1, DIV/REM): IDLE -> DONE directly; quotient = d0, remainder = 0.
REQ-023 DONE: y and out_valid SHALL hold stable until out_ready; DONE & out_ready -> IDLE; no new accept in the same cycle.
REQ-024 flush high in any state SHALL force IDLE next cycle, dropping the operation; flush coincident with in_valid in IDLE SHALL NOT accept.
REQ-025 y SHALL be 0 whenever out_valid is low.

Reset
REQ-026 reset SHALL put state to IDLE, clear iteration counter, operand and accumulator registers; in cycle after reset: in_ready=1, out_valid=0, y=0.
REQ-027 reset mid-CALC or in DONE SHALL discard the operation with no out_valid pulse; reset has priority over flush and in_valid.

Structure
REQ-028 muldiv_op_t enum and its encodings SHALL live in the shared alu_pkg alongside the ALU op codes; state enum stays local.
REQ-029 Iteration counter width SHALL be $clog2(XLEN)+1.
REQ-030 No sub-module; single module with one FSM and a shared shift/accumulate datapath for both multiply and divide.

Verification
REQ-031 XLEN=32, MUL d0=7 d1=0xFFFFFFFD -> y=0xFFFFFFEB, out_valid first at t+33.
REQ-032 XLEN=32, d0=d1=0x80000000: MULH -> 0x40000000; MULHU -> 0x40000000; d0=d1=0xFFFFFFFF: MULHSU -> 0xFFFFFFFF, MULHU -> 0xFFFFFFFE.
REQ-033 XLEN=32, DIV d0=0xFFFFFFF9 d1=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; latency 33.
REQ-034 XLEN=32, DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each out_valid at t+1.
REQ-035 XLEN=64, DIV is_word_op d0=0x00000001FFFFFFF9 d1=2 -> y=0xFFFFFFFFFFFFFFFD at t+33; MUL non-word 0x100000000*0x100000000 -> 0 at t+65.
REQ-036 Hold out_ready low 5 cycles in DONE -> y stable, in_ready low; flush at CALC cycle 10 -> in_ready next cycle, no out_valid; reset mid-CALC -> same, y=0.
